// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Buffered UART transmitter. Bytes are pushed into a small FIFO and sent as
// frames: a start bit (0), DATA_BITS data bits LSB first, an optional parity
// bit, and one or two stop bits (1). Every bit is held for max(baud_div,1)
// clock cycles. Frames follow each other with no idle cycle while the FIFO
// has data and the enable bit is set.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : PARITY state present, config_in[1] enables parity and
//               config_in[2] selects odd parity.
//   undefined : no parity logic, config_in[2:1] ignored, frames never
//               carry a parity bit.
//
// Ports
//   clk         in   single clock, all state on the rising edge
//   reset       in   asynchronous, active-low reset
//   new_data    in   push strobe, one FIFO entry per high cycle
//   data_in     in   [DATA_BITS] byte sampled together with new_data
//   config_in   in   [4] [0] enable, [1] parity on, [2] odd parity,
//                        [3] two stop bits
//   baud_div    in   [BAUD_W] clock cycles per bit (0 behaves as 1)
//   clr_ovf     in   clears the sticky overflow flag
//   tx          out  serial line, idle high
//   busy        out  high while a frame is on the line
//   fifo_full   out  FIFO holds FIFO_DEPTH entries
//   fifo_empty  out  FIFO holds no entries
//   fifo_count  out  [$clog2(FIFO_DEPTH+1)] occupied entries
//   overflow    out  sticky: a push was dropped because the FIFO was full
//   state_dbg   out  [3] current FSM state encoding
//
// Push handshake: new_data is a valid strobe with no ready back-pressure.
// A push is accepted when the FIFO is not full, or when it is full and a
// pop happens in the same cycle; any other push is dropped and raises
// overflow. The producer watches fifo_full to avoid losing data.
//
// tx and busy are registered from the FSM state so the line is glitch free;
// they follow the state by one cycle, which gives a two-cycle latency from a
// push into an empty idle FIFO to the falling edge of the start bit.
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            new_data,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic [3:0]                      config_in,
    input  logic [BAUD_W-1:0]               baud_div,
    input  logic                            clr_ovf,
    output logic                            tx,
    output logic                            busy,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic [2:0]                      state_dbg
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    // Encodings are fixed across builds so state_dbg reads the same with
    // or without the parity feature.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] head;
    logic                 push_ok;
    logic                 pop;
    logic                 ovf_evt;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_count = count;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = new_data && (!fifo_full || pop);
    assign ovf_evt = new_data && !push_ok;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A new drop wins over a clear in the same cycle.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    logic [2:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    div_q;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 two_stop_q;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q;
    logic                 par_bit_q;
`else
    logic                 unused_cfg;
    assign unused_cfg = ^config_in[2:1];
`endif
    logic                 bit_end;
    logic                 last_stop;
    logic [BAUD_W-1:0]    load_cnt;
    logic [BAUD_W-1:0]    reload_cnt;
    logic                 tx_next;

    // baud_cnt counts down to zero; a divisor of 0 is treated as 1.
    assign bit_end    = (baud_cnt == '0);
    assign load_cnt   = (baud_div == '0) ? '0 : baud_div - BAUD_W'(1);
    assign reload_cnt = (div_q == '0) ? '0 : div_q - BAUD_W'(1);

    // stop_idx counts stop bits sent: 0 for the first, 1 for the second.
    assign last_stop = (state == STOP) && bit_end && (stop_idx == two_stop_q);

    // Pop from IDLE, or on the final stop cycle to run frames back to back.
    // Enable is sampled live so a cleared enable lets the frame finish but
    // blocks the next one.
    assign pop = ((state == IDLE) || last_stop) && !fifo_empty && config_in[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            div_q      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            two_stop_q <= 1'b0;
            shift      <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else if (pop) begin
            // Frame settings are captured here so mid-frame changes wait
            // for the next frame.
            state      <= START;
            div_q      <= baud_div;
            baud_cnt   <= load_cnt;
            two_stop_q <= config_in[3];
            shift      <= head;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= config_in[1];
            par_bit_q  <= (^head) ^ config_in[2];
`endif
        end else if (state != IDLE) begin
            baud_cnt <= bit_end ? reload_cnt : baud_cnt - BAUD_W'(1);
            if (bit_end) begin
                case (state)
                    START: begin
                        state <= DATA;
                    end
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + BIT_W'(1);
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= par_en_q ? PARITY : STOP;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        if (stop_idx == two_stop_q) begin
                            state <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line driver
    // -------------------------------------------------------------------------
    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par_bit_q;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= tx_next;
            busy <= (state != IDLE);
        end
    end

    assign state_dbg = state;

endmodule
